// File: rtl/mux_after_data_memory_pkg.sv
// Shared definitions for the write-back mux slice: default widths and
// the LoadSize encodings used by the load formatter and the top.
package mux_after_data_memory_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_W  = 5;

  // LoadSize field encodings; LS_RSVD is treated as a full word.
  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_HALF = 2'b01,
    LS_BYTE = 2'b10,
    LS_RSVD = 2'b11
  } loadSizeE;

endpackage

// File: rtl/mux_after_data_memory_load_formatter.sv
// Load formatter: picks the addressed byte/halfword lane out of the raw
// memory word (little-endian) and zero- or sign-extends it to DATA_W.
// Word and reserved sizes pass the raw word through untouched.
module load_formatter
  import mux_after_data_memory_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] readData,
  input  logic [1:0]        loadSize,
  input  logic              loadUnsigned,
  input  logic [1:0]        addrLow,
  output logic [DATA_W-1:0] formatted
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;
  logic        byteFill;
  logic        halfFill;

  // Lane extraction; halfword lane ignores addrLow[0] by design.
  always_comb begin
    byteLane = readData[8*addrLow +: 8];
    halfLane = readData[16*addrLow[1] +: 16];
    byteFill = ~loadUnsigned & byteLane[7];
    halfFill = ~loadUnsigned & halfLane[15];
  end

  // Size select and extension to the full datapath width.
  always_comb begin
    formatted = readData;
    case (loadSize)
      LS_HALF: formatted = {{(DATA_W-16){halfFill}}, halfLane};
      LS_BYTE: formatted = {{(DATA_W-8){byteFill}}, byteLane};
      default: formatted = readData;
    endcase
  end

endmodule

// File: rtl/mux_after_data_memory.sv
// MEM/WB write-back select: chooses between the formatted load value and
// the ALU result, flags misaligned loads, and registers the write-back
// bundle for one cycle. Register index 0 never produces a write enable.
module mux_after_data_memory
  import mux_after_data_memory_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_W  = DEFAULT_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] Result,
  input  logic [1:0]        LoadSize,
  input  logic              LoadUnsigned,
  input  logic [1:0]        AddrLow,
  input  logic              RegWriteIn,
  input  logic [REG_W-1:0]  WriteRegIn,
  output logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] WbData,
  output logic              WbRegWrite,
  output logic [REG_W-1:0]  WbWriteReg,
  output logic              Misaligned
);

  logic [DATA_W-1:0] loadValue;

  load_formatter #(
    .DATA_W(DATA_W)
  ) uFormatter (
    .readData    (ReadData),
    .loadSize    (LoadSize),
    .loadUnsigned(LoadUnsigned),
    .addrLow     (AddrLow),
    .formatted   (loadValue)
  );

  // Write-back select and misalignment flag; the flag is advisory only.
  always_comb begin
    WriteData  = MemtoReg ? loadValue : Result;
    Misaligned = 1'b0;
    if (MemtoReg) begin
      if (LoadSize == LS_HALF && AddrLow[0])
        Misaligned = 1'b1;
      else if (LoadSize == LS_WORD && AddrLow != 2'b00)
        Misaligned = 1'b1;
    end
  end

  // Write-back registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WbData     <= '0;
      WbRegWrite <= 1'b0;
      WbWriteReg <= '0;
    end else begin
      WbData     <= WriteData;
      WbRegWrite <= RegWriteIn && (WriteRegIn != '0);
      WbWriteReg <= WriteRegIn;
    end
  end

endmodule

// File: tb/tb_mux_after_data_memory.sv
// Directed bench for the write-back mux: hand-computed vectors for the
// select, byte/halfword formatting, misalignment flag, write-enable gating
// and asynchronous reset.
module tb_mux_after_data_memory;

  logic        clk;
  logic        rst_n;
  logic        MemtoReg;
  logic [31:0] ReadData;
  logic [31:0] Result;
  logic [1:0]  LoadSize;
  logic        LoadUnsigned;
  logic [1:0]  AddrLow;
  logic        RegWriteIn;
  logic [4:0]  WriteRegIn;
  logic [31:0] WriteData;
  logic [31:0] WbData;
  logic        WbRegWrite;
  logic [4:0]  WbWriteReg;
  logic        Misaligned;

  int checks = 0;
  int errors = 0;

  mux_after_data_memory dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemtoReg    (MemtoReg),
    .ReadData    (ReadData),
    .Result      (Result),
    .LoadSize    (LoadSize),
    .LoadUnsigned(LoadUnsigned),
    .AddrLow     (AddrLow),
    .RegWriteIn  (RegWriteIn),
    .WriteRegIn  (WriteRegIn),
    .WriteData   (WriteData),
    .WbData      (WbData),
    .WbRegWrite  (WbRegWrite),
    .WbWriteReg  (WbWriteReg),
    .Misaligned  (Misaligned)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one vector at the falling edge, check combinational outputs,
  // then check the registered copy just after the next rising edge.
  task automatic applyVec(input string tag, input logic m, input logic [1:0] ls,
                          input logic lu, input logic [1:0] al,
                          input logic [31:0] rd, input logic [31:0] res,
                          input logic rw, input logic [4:0] wreg,
                          input logic [31:0] expData, input logic expMis,
                          input logic expRw);
    @(negedge clk);
    MemtoReg     = m;
    LoadSize     = ls;
    LoadUnsigned = lu;
    AddrLow      = al;
    ReadData     = rd;
    Result       = res;
    RegWriteIn   = rw;
    WriteRegIn   = wreg;
    #1;
    checkVal({tag, ".WriteData"}, WriteData, expData);
    checkVal({tag, ".Misaligned"}, {31'd0, Misaligned}, {31'd0, expMis});
    @(posedge clk);
    #1;
    checkVal({tag, ".WbData"}, WbData, expData);
    checkVal({tag, ".WbWriteReg"}, {27'd0, WbWriteReg}, {27'd0, wreg});
    checkVal({tag, ".WbRegWrite"}, {31'd0, WbRegWrite}, {31'd0, expRw});
  endtask

  initial begin
    rst_n        = 1'b0;
    MemtoReg     = 1'b1;
    LoadSize     = 2'b10;
    LoadUnsigned = 1'b0;
    AddrLow      = 2'd2;
    ReadData     = 32'h80FF7F01;
    Result       = 32'h0;
    RegWriteIn   = 1'b1;
    WriteRegIn   = 5'd7;

    // Reset holds registers at zero across edges; comb path still works.
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst.WbData", WbData, 32'h0);
    checkVal("rst.WbRegWrite", {31'd0, WbRegWrite}, 32'h0);
    checkVal("rst.WbWriteReg", {27'd0, WbWriteReg}, 32'h0);
    checkVal("rst.WriteData", WriteData, 32'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // tag, MemtoReg, LoadSize, Unsigned, AddrLow, ReadData, Result, RegWrite, Reg, expData, expMis, expRw
    applyVec("word",      1'b1, 2'b00, 1'b0, 2'd0, 32'h00000100, 32'h00000101, 1'b1, 5'd3, 32'h00000100, 1'b0, 1'b1);
    applyVec("alu",       1'b0, 2'b00, 1'b0, 2'd0, 32'h00000100, 32'h00000101, 1'b1, 5'd4, 32'h00000101, 1'b0, 1'b1);
    applyVec("byte2s",    1'b1, 2'b10, 1'b0, 2'd2, 32'h80FF7F01, 32'h12345678, 1'b1, 5'd1, 32'hFFFFFFFF, 1'b0, 1'b1);
    applyVec("byte1s",    1'b1, 2'b10, 1'b0, 2'd1, 32'h80FF7F01, 32'h12345678, 1'b1, 5'd2, 32'h0000007F, 1'b0, 1'b1);
    applyVec("byte3u",    1'b1, 2'b10, 1'b1, 2'd3, 32'h80FF7F01, 32'h12345678, 1'b1, 5'd9, 32'h00000080, 1'b0, 1'b1);
    applyVec("byte0s",    1'b1, 2'b10, 1'b0, 2'd0, 32'h80FF7F81, 32'h0, 1'b0, 5'd9, 32'hFFFFFF81, 1'b0, 1'b0);
    applyVec("half2s",    1'b1, 2'b01, 1'b0, 2'd2, 32'h8001FFFE, 32'h0, 1'b1, 5'd10, 32'hFFFF8001, 1'b0, 1'b1);
    applyVec("half0u",    1'b1, 2'b01, 1'b1, 2'd0, 32'h8001FFFE, 32'h0, 1'b1, 5'd11, 32'h0000FFFE, 1'b0, 1'b1);
    applyVec("half1mis",  1'b1, 2'b01, 1'b1, 2'd1, 32'h8001FFFE, 32'h0, 1'b1, 5'd12, 32'h0000FFFE, 1'b1, 1'b1);
    applyVec("half3mis",  1'b1, 2'b01, 1'b0, 2'd3, 32'h8001FFFE, 32'h0, 1'b1, 5'd13, 32'hFFFF8001, 1'b1, 1'b1);
    applyVec("wordmis",   1'b1, 2'b00, 1'b0, 2'd2, 32'hDEADBEEF, 32'h0, 1'b1, 5'd14, 32'hDEADBEEF, 1'b1, 1'b1);
    applyVec("rsvd",      1'b1, 2'b11, 1'b0, 2'd3, 32'hCAFE8000, 32'h0, 1'b1, 5'd15, 32'hCAFE8000, 1'b0, 1'b1);
    applyVec("alunomis",  1'b0, 2'b01, 1'b0, 2'd1, 32'h8001FFFE, 32'h55AA00FF, 1'b1, 5'd16, 32'h55AA00FF, 1'b0, 1'b1);
    applyVec("reg0",      1'b0, 2'b00, 1'b0, 2'd0, 32'h0, 32'h00000042, 1'b1, 5'd0, 32'h00000042, 1'b0, 1'b0);
    applyVec("reg5",      1'b0, 2'b00, 1'b0, 2'd0, 32'h0, 32'hA5A5A5A5, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle while WbData holds 0xA5A5A5A5.
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst.WbData", WbData, 32'h0);
    checkVal("arst.WbRegWrite", {31'd0, WbRegWrite}, 32'h0);
    checkVal("arst.WbWriteReg", {27'd0, WbWriteReg}, 32'h0);
    checkVal("arst.WriteData", WriteData, 32'hA5A5A5A5);

    // First edge after release captures normally.
    @(negedge clk);
    rst_n = 1'b1;
    applyVec("postrst",   1'b1, 2'b10, 1'b1, 2'd1, 32'h80FF7F01, 32'h0, 1'b1, 5'd31, 32'h0000007F, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_after_data_memory.md
MUX_AFTER_DATA_MEMORY -- requirements
Module: mux_after_data_memory

Interface
REQ-001 Parameter: DATA_W, default 32, datapath width of ReadData, Result, WriteData and WbData.
REQ-002 Parameter: REG_W, default 5, register-index width.
REQ-003 clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 MemtoReg  input  1  1 = select formatted ReadData, 0 = select Result.
REQ-006 ReadData  input  DATA_W  raw word from data memory.
REQ-007 Result  input  DATA_W  ALU result.
REQ-008 LoadSize  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
REQ-009 LoadUnsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-010 AddrLow  input  2  byte-address bits [1:0] of the load.
REQ-011 RegWriteIn  input  1  register-file write enable from the MEM stage.
REQ-012 WriteRegIn  input  REG_W  destination register index.
REQ-013 WriteData  output  DATA_W  combinational selected write-back value.
REQ-014 WbData  output  DATA_W  registered copy of WriteData.
REQ-015 WbRegWrite  output  1  registered write enable.
REQ-016 WbWriteReg  output  REG_W  registered destination index.
REQ-017 Misaligned  output  1  combinational flag for a misaligned load.

Function
REQ-018 WriteData SHALL equal Result when MemtoReg=0 and the formatted load value when MemtoReg=1, with zero-cycle latency.
REQ-019 Word load (LoadSize 00 or reserved 11) SHALL pass ReadData unchanged, regardless of AddrLow.
REQ-020 Byte load SHALL select lane ReadData[8*AddrLow +: 8] (little-endian) and extend to DATA_W per LoadUnsigned.
REQ-021 Halfword load SHALL select ReadData[16*AddrLow[1] +: 16] and extend per LoadUnsigned; AddrLow[0] is ignored for lane selection.
REQ-022 Misaligned SHALL be 1 only when MemtoReg=1 and either (LoadSize=01 and AddrLow[0]=1) or (LoadSize=00 and AddrLow!=00); otherwise 0.
REQ-023 Misaligned SHALL NOT alter WriteData.
REQ-024 On each rising clk edge with rst_n=1: WbData <= WriteData, WbWriteReg <= WriteRegIn, WbRegWrite <= RegWriteIn AND (WriteRegIn != 0).
REQ-025 Registered outputs SHALL have exactly one cycle of latency; no stall or handshake inputs exist.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force WbData=0, WbRegWrite=0 and WbWriteReg=0.
REQ-027 Combinational outputs (WriteData, Misaligned) SHALL remain functional during reset.
REQ-028 First rising edge after rst_n deasserts SHALL capture normally.

Structure
REQ-029 A shared package SHALL hold DATA_W/REG_W defaults and the LoadSize encodings (LS_WORD, LS_HALF, LS_BYTE).
REQ-030 Lane selection and extension SHALL be a sub-module named load_formatter; the top holds the mux and the write-back registers.

Verification
REQ-031 MemtoReg=1, LoadSize=00, ReadData=0x00000100, Result=0x00000101 -> WriteData=0x00000100; next edge WbData=0x00000100.
REQ-032 MemtoReg=0, same data -> WriteData=0x00000101.
REQ-033 MemtoReg=1, LoadSize=10, ReadData=0x80FF7F01: AddrLow=2, LoadUnsigned=0 -> 0xFFFFFFFF; AddrLow=1 -> 0x0000007F; AddrLow=3, LoadUnsigned=1 -> 0x00000080.
REQ-034 MemtoReg=1, LoadSize=01, ReadData=0x8001FFFE: AddrLow=2, signed -> 0xFFFF8001; AddrLow=0, unsigned -> 0x0000FFFE; AddrLow=1 -> Misaligned=1.
REQ-035 RegWriteIn=1 with WriteRegIn=0 -> WbRegWrite=0 after the edge; with WriteRegIn=5 -> WbRegWrite=1 and WbWriteReg=5.
REQ-036 Assert rst_n=0 between clock edges while WbData is nonzero -> WbData, WbRegWrite and WbWriteReg read 0 immediately, before the next edge.
